ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port synchronous program/data RAM block between the CPU processor port (requester 0) and a secondary master such as a UART loader or debug DMA (requester 1). It sits between the requesters' RAM-side signals and the RAM block. It grants one access per cycle and tracks read latency so each requester gets its own read data. It presents the same busy, rd_ready and rd_ack handshake the processor port already uses.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rd_return_pipe.sv | 38 +++
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the two-requester RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int NUM_REQ = 2;

  // Requester index: 0 = CPU processor port, 1 = secondary master.
  typedef logic req_id_t;

  // Tag carried alongside each accepted read until its data returns.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/rd_return_pipe.sv
// ============================================================================
// Module      : rd_return_pipe
// Description : RD_LAT-stage delay line of read tags; the emerging tag marks
//               the cycle in which RAM read data is valid for that requester.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_return_pipe
  import arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [RD_LAT-1:0] r_stage;

  // Shift tags one stage per cycle; reset discards every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign tag_out = r_stage[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one single-port synchronous RAM between the CPU port
//               (requester 0) and a secondary master (requester 1). One access
//               per cycle, per-requester read return with ready/ack handshake.
//               Build option ARB_ROUND_ROBIN_EN: owner/burst fairness with
//               MAX_BURST limit; when undefined, port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  rq_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  rq_wr_data,
  input  logic [NUM_REQ-1:0]              rq_wr_en,
  input  logic [NUM_REQ-1:0]              rq_rd_en,
  output logic [NUM_REQ-1:0]              rq_busy,
  output logic [NUM_REQ-1:0][DATA_W-1:0]  rq_rd_data,
  output logic [NUM_REQ-1:0]              rq_rd_ready,
  input  logic [NUM_REQ-1:0]              rq_rd_ack,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_wr_data,
  output logic                            ram_wr_en,
  output logic                            ram_rd_en,
  input  logic [DATA_W-1:0]               ram_rd_data
);

  logic [NUM_REQ-1:0]             w_req;
  logic [NUM_REQ-1:0]             w_elig;
  logic [NUM_REQ-1:0]             w_grant;
  req_id_t                        w_win;
  rd_tag_t                        w_tag_in;
  rd_tag_t                        w_tag_out;

  logic [NUM_REQ-1:0]             r_inflight;
  logic [NUM_REQ-1:0]             r_rd_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0]              r_last_addr;
  logic [DATA_W-1:0]              r_last_wdata;

  // Requests are masked while reset is held so no access leaks to the RAM.
  // A read is only eligible once the previous read on that port has been
  // returned and acknowledged; a write (even with rd_en set) always is.
  assign w_req  = (rq_wr_en | rq_rd_en) & {NUM_REQ{rst_n}};
  assign w_elig = (rq_wr_en | (rq_rd_en & ~r_inflight & ~r_rd_ready)) & {NUM_REQ{rst_n}};
  assign w_win  = w_grant[1];

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t    r_owner;
  logic [7:0] r_burst;

  // Owner keeps the RAM while under its burst budget, else hand over.
  always_comb begin
    w_grant = w_elig;
    if (&w_elig) begin
      w_grant = '0;
      if (r_burst < 8'(MAX_BURST)) begin
        w_grant[r_owner] = 1'b1;
      end else begin
        w_grant[~r_owner] = 1'b1;
      end
    end
  end

  // Track last granted port and its saturating run length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_burst <= 8'd0;
    end else if (|w_grant) begin
      if (w_win == r_owner) begin
        if (r_burst < 8'(MAX_BURST)) begin
          r_burst <= r_burst + 8'd1;
        end
      end else begin
        r_owner <= w_win;
        r_burst <= 8'd1;
      end
    end
  end
`else
  // Fixed priority: port 0 wins whenever it is eligible.
  assign w_grant = {w_elig[1] & ~w_elig[0], w_elig[0]};
`endif

  assign rq_busy = w_req & ~w_grant;

  // Steer the winner onto the RAM; address/data hold when idle.
  always_comb begin
    ram_addr    = r_last_addr;
    ram_wr_data = r_last_wdata;
    ram_wr_en   = 1'b0;
    ram_rd_en   = 1'b0;
    if (|w_grant) begin
      ram_addr    = rq_addr[w_win];
      ram_wr_data = rq_wr_data[w_win];
      ram_wr_en   = rq_wr_en[w_win];
      ram_rd_en   = rq_rd_en[w_win] & ~rq_wr_en[w_win];
    end
  end

  // Remember the last driven address/data for the idle-hold behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else if (|w_grant) begin
      r_last_addr  <= ram_addr;
      r_last_wdata <= ram_wr_data;
    end
  end

  assign w_tag_in.valid = ram_rd_en;
  assign w_tag_in.id    = w_win;

  rd_return_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_return_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (w_tag_in),
    .tag_out (w_tag_out)
  );

  // Capture returning data for its owner; clear ready on acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_rd_ready <= '0;
      r_rd_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq_rd_ack[i] && r_rd_ready[i]) begin
          r_rd_ready[i] <= 1'b0;
        end
      end
      if (ram_rd_en) begin
        r_inflight[w_win] <= 1'b1;
      end
      if (w_tag_out.valid) begin
        r_inflight[w_tag_out.id] <= 1'b0;
        r_rd_ready[w_tag_out.id] <= 1'b1;
        r_rd_data[w_tag_out.id]  <= ram_rd_data;
      end
    end
  end

  assign rq_rd_ready = r_rd_ready;
  assign rq_rd_data  = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed self-checking bench for ram_arbiter with a simple
//               behavioural RAM (RD_LAT cycles of read latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int L  = 3;
  localparam int MB = 4;

  logic                clk;
  logic                rst_n;
  logic [1:0][AW-1:0]  rq_addr;
  logic [1:0][DW-1:0]  rq_wr_data;
  logic [1:0]          rq_wr_en;
  logic [1:0]          rq_rd_en;
  logic [1:0]          rq_busy;
  logic [1:0][DW-1:0]  rq_rd_data;
  logic [1:0]          rq_rd_ready;
  logic [1:0]          rq_rd_ack;
  logic [AW-1:0]       ram_addr;
  logic [DW-1:0]       ram_wr_data;
  logic                ram_wr_en;
  logic                ram_rd_en;
  logic [DW-1:0]       ram_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RD_LAT    (L),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rq_addr     (rq_addr),
    .rq_wr_data  (rq_wr_data),
    .rq_wr_en    (rq_wr_en),
    .rq_rd_en    (rq_rd_en),
    .rq_busy     (rq_busy),
    .rq_rd_data  (rq_rd_data),
    .rq_rd_ready (rq_rd_ready),
    .rq_rd_ack   (rq_rd_ack),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_data (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: address sampled at the edge, q after L edges.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] q_pipe [L];

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr[7:0]] <= ram_wr_data;
    q_pipe[0] <= mem[ram_addr[7:0]];
    for (int k = 1; k < L; k++) q_pipe[k] <= q_pipe[k-1];
  end
  assign ram_rd_data = q_pipe[L-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rq_addr    = '0;
    rq_wr_data = '0;
    rq_wr_en   = '0;
    rq_rd_en   = '0;
    rq_rd_ack  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int exp_win;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    for (int k = 0; k < L; k++) q_pipe[k] = '0;

    // ---------------- reset state ----------------
    idle_inputs();
    rst_n = 1'b0;
    tick();
    check("rst_busy",     32'(rq_busy), 32'h0);
    check("rst_ready",    32'(rq_rd_ready), 32'h0);
    check("rst_rdata",    32'(rq_rd_data), 32'h0);
    check("rst_addr",     32'(ram_addr), 32'h0);
    check("rst_wdata",    32'(ram_wr_data), 32'h0);
    check("rst_en",       32'({ram_wr_en, ram_rd_en}), 32'h0);
    rst_n = 1'b1;
    tick();

    // ---------------- port 0 write 0xBEEF @ 0x10 ----------------
    rq_addr[0] = 24'h000010; rq_wr_data[0] = 16'hBEEF; rq_wr_en[0] = 1'b1;
    #1;
    check("wr_en",    32'(ram_wr_en), 32'h1);
    check("wr_addr",  32'(ram_addr), 32'h10);
    check("wr_data",  32'(ram_wr_data), 32'hBEEF);
    check("wr_busy",  32'(rq_busy), 32'h0);
    tick();
    rq_wr_en[0] = 1'b0; rq_wr_data[0] = 16'h0; rq_addr[0] = 24'h0;
    #1;
    check("idle_wr_en",  32'(ram_wr_en), 32'h0);
    check("idle_addr_hold", 32'(ram_addr), 32'h10);

    // ---------------- port 0 read back 0x10 ----------------
    rq_addr[0] = 24'h000010; rq_rd_en[0] = 1'b1;
    #1;
    check("rd_en",   32'(ram_rd_en), 32'h1);
    tick();                              // accepted at E0
    rq_rd_en[0] = 1'b0;
    check("rd_lat0", 32'(rq_rd_ready[0]), 32'h0);
    for (int k = 1; k < L; k++) begin
      tick();
      check("rd_lat_wait", 32'(rq_rd_ready[0]), 32'h0);
    end
    tick();                              // edge E0+L
    check("rd_ready", 32'(rq_rd_ready[0]), 32'h1);
    check("rd_data",  32'(rq_rd_data[0]), 32'hBEEF);
    rq_rd_ack[0] = 1'b1;
    tick();
    rq_rd_ack[0] = 1'b0;
    check("rd_ack_clr", 32'(rq_rd_ready[0]), 32'h0);

    // ---------------- both ports writing continuously ----------------
    do_reset();
    rq_addr[0] = 24'h50; rq_wr_data[0] = 16'hA0A0; rq_wr_en[0] = 1'b1;
    rq_addr[1] = 24'h60; rq_wr_data[1] = 16'hB1B1; rq_wr_en[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_win = (c / MB) % 2;
`else
      exp_win = 0;
`endif
      #1;
      check("burst_data", 32'(ram_wr_data), (exp_win == 0) ? 32'hA0A0 : 32'hB1B1);
      check("burst_busy", 32'(rq_busy), (exp_win == 0) ? 32'h2 : 32'h1);
      tick();
    end
    rq_wr_en[0] = 1'b0;
    #1;
    check("p1_alone_busy", 32'(rq_busy), 32'h0);
    check("p1_alone_data", 32'(ram_wr_data), 32'hB1B1);
    tick();
    idle_inputs();
    tick();

    // ---------------- port 1 read with delayed ack ----------------
    rq_addr[0] = 24'h20; rq_wr_data[0] = 16'h1234; rq_wr_en[0] = 1'b1;
    tick();
    idle_inputs();
    rq_addr[1] = 24'h20; rq_rd_en[1] = 1'b1;
    #1;
    check("p1_rd_busy", 32'(rq_busy), 32'h0);
    tick();                              // accepted
    rq_rd_en[1] = 1'b0;
    for (int k = 0; k < L; k++) tick();
    check("p1_ready", 32'(rq_rd_ready[1]), 32'h1);
    check("p1_data",  32'(rq_rd_data[1]), 32'h1234);
    tick();
    tick();
    rq_addr[1] = 24'h10; rq_rd_en[1] = 1'b1;
    rq_addr[0] = 24'h40; rq_wr_data[0] = 16'hAAAA; rq_wr_en[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("p1_blocked_busy", 32'(rq_busy), 32'h2);
      check("p0_wr_through",   32'(ram_wr_data), 32'hAAAA);
      tick();
    end
    check("p1_data_hold", 32'(rq_rd_data[1]), 32'h1234);
    rq_wr_en[0] = 1'b0;
    rq_rd_ack[1] = 1'b1;
    #1;
    check("ack_cycle_busy", 32'(rq_busy), 32'h2);
    tick();
    rq_rd_ack[1] = 1'b0;
    #1;
    check("after_ack_ready", 32'(rq_rd_ready[1]), 32'h0);
    check("after_ack_busy",  32'(rq_busy), 32'h0);
    check("after_ack_rd_en", 32'(ram_rd_en), 32'h1);
    check("after_ack_addr",  32'(ram_addr), 32'h10);
    tick();
    rq_rd_en[1] = 1'b0;
    for (int k = 0; k < L; k++) tick();
    check("p1_rd2_ready", 32'(rq_rd_ready[1]), 32'h1);
    check("p1_rd2_data",  32'(rq_rd_data[1]), 32'hBEEF);
    rq_rd_ack[1] = 1'b1;
    tick();
    rq_rd_ack[1] = 1'b0;

    // ---------------- write+read together: write only ----------------
    rq_addr[0] = 24'h30; rq_wr_data[0] = 16'h5555;
    rq_wr_en[0] = 1'b1; rq_rd_en[0] = 1'b1;
    #1;
    check("wr_rd_wr_en", 32'(ram_wr_en), 32'h1);
    check("wr_rd_rd_en", 32'(ram_rd_en), 32'h0);
    check("wr_rd_busy",  32'(rq_busy), 32'h0);
    tick();
    idle_inputs();
    for (int k = 0; k < L + 2; k++) begin
      tick();
      check("wr_rd_no_ready", 32'(rq_rd_ready), 32'h0);
    end
    check("wr_rd_mem", 32'(mem[8'h30]), 32'h5555);

    // ---------------- reset during an in-flight read ----------------
    rq_addr[1] = 24'h20; rq_rd_en[1] = 1'b1;
    tick();                              // accepted
    rq_rd_en[1] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr",  32'(ram_addr), 32'h0);
    check("mid_rst_wdata", 32'(ram_wr_data), 32'h0);
    check("mid_rst_rdata", 32'(rq_rd_data), 32'h0);
    check("mid_rst_en",    32'({ram_wr_en, ram_rd_en, rq_busy, rq_rd_ready}), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < L + 3; k++) begin
      tick();
      check("post_rst_no_ready", 32'(rq_rd_ready), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
